// File: rtl/ram_burst.sv
// Single-port word RAM with a direct CPU port and a burst engine that streams
// consecutive, wrapping addresses into or out of the array.
module ram_burst #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    output logic [WIDTH-1:0]  out,
    input  logic              bst_start,
    input  logic              bst_write,
    input  logic [ADDR_W-1:0] bst_base,
    input  logic [ADDR_W-1:0] bst_len,
    input  logic [WIDTH-1:0]  bst_din,
    input  logic              bst_din_valid,
    output logic              bst_din_ready,
    output logic [WIDTH-1:0]  bst_dout,
    output logic              bst_dout_valid,
    output logic              bst_busy,
    output logic              bst_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              drain_q, drain_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem [DEPTH];

    // The array has exactly one write port, shared by the direct port (IDLE
    // only) and the burst writer (WRITE only).
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        rem_d        = rem_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        drain_d      = drain_q;
        mem_we       = 1'b0;
        mem_waddr    = addr;
        mem_wdata    = in;

        case (state_q)
            IDLE: begin
                mem_we = load;
                if (bst_start) begin
                    ptr_d   = bst_base;
                    rem_d   = bst_len;
                    drain_d = 1'b0;
                    state_d = bst_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (bst_din_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = bst_din;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        rem_d = rem_q - ADDR_W'(1);
                    end
                end
            end
            READ: begin
                // One idle cycle after the last word so bst_done follows the final strobe.
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = DONE;
                end else begin
                    dout_d       = mem[ptr_q];
                    dout_valid_d = 1'b1;
                    ptr_d        = ptr_q + ADDR_W'(1);
                    if (rem_q == '0) begin
                        drain_d = 1'b1;
                    end else begin
                        rem_d = rem_q - ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rem_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            drain_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            drain_q      <= drain_d;
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign out            = mem[addr];
    assign bst_din_ready  = (state_q == WRITE);
    assign bst_dout       = dout_q;
    assign bst_dout_valid = dout_valid_q;
    assign bst_busy       = (state_q != IDLE);
    assign bst_done       = (state_q == DONE);

endmodule

// File: tb/tb_ram_burst.sv
// Self-checking bench for ram_burst: direct-port vector table, directed burst
// corner cases and randomized traffic against an array model of the memory.
module tb_ram_burst;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] dir_in = '0;
    logic [5:0]  dir_addr = '0;
    logic        dir_load = 1'b0;
    logic [15:0] dir_out;
    logic        bst_start = 1'b0;
    logic        bst_write = 1'b0;
    logic [5:0]  bst_base = '0;
    logic [5:0]  bst_len = '0;
    logic [15:0] bst_din = '0;
    logic        bst_din_valid = 1'b0;
    logic        bst_din_ready;
    logic [15:0] bst_dout;
    logic        bst_dout_valid;
    logic        bst_busy;
    logic        bst_done;

    int total = 0;
    int bad = 0;

    logic [15:0] model [64];
    logic [15:0] wdata [64];

    typedef struct {
        logic        load;
        logic [5:0]  addr;
        logic [15:0] din;
        logic [15:0] exp;
    } dvec_t;

    dvec_t dvecs [7];

    ram_burst #(.WIDTH(16), .ADDR_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .in            (dir_in),
        .addr          (dir_addr),
        .load          (dir_load),
        .out           (dir_out),
        .bst_start     (bst_start),
        .bst_write     (bst_write),
        .bst_base      (bst_base),
        .bst_len       (bst_len),
        .bst_din       (bst_din),
        .bst_din_valid (bst_din_valid),
        .bst_din_ready (bst_din_ready),
        .bst_dout      (bst_dout),
        .bst_dout_valid(bst_dout_valid),
        .bst_busy      (bst_busy),
        .bst_done      (bst_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input dvec_t v);
        dir_load = v.load;
        dir_addr = v.addr;
        dir_in   = v.din;
        #1;
        if (!v.load) checkOutput("direct_comb", dir_out, v.exp);
        tick();
        dir_load = 1'b0;
        if (v.load) model[v.addr] = v.din;
        checkOutput("direct_out", dir_out, v.exp);
    endtask

    task automatic peek(input string name, input logic [5:0] a, input logic [15:0] exp);
        dir_addr = a;
        #1;
        checkOutput(name, dir_out, exp);
    endtask

    task automatic doWriteBurst(input logic [5:0] base, input int nwords, input int stallBefore,
                                input bit randStall, input bit maskLoad);
        int readyCycles = 0;
        int stalls = 0;
        bst_start = 1'b1;
        bst_write = 1'b1;
        bst_base  = base;
        bst_len   = 6'(nwords - 1);
        tick();
        bst_start = 1'b0;
        checkOutput("wr_busy", bst_busy, 1);
        if (maskLoad) begin
            dir_load = 1'b1;
            dir_addr = 6'd5;
            dir_in   = 16'hffff;
        end
        for (int i = 0; i < nwords; i++) begin
            if (i == stallBefore || (randStall && $urandom_range(0, 3) == 0)) begin
                bst_din_valid = 1'b0;
                bst_din = 16'hbad0;
                if (bst_din_ready) readyCycles++;
                stalls++;
                tick();
            end
            bst_din_valid = 1'b1;
            bst_din = wdata[i];
            if (bst_din_ready) readyCycles++;
            tick();
            model[6'(int'(base) + i)] = wdata[i];
            if (i < nwords - 1) checkOutput("wr_done_early", bst_done, 0);
        end
        bst_din_valid = 1'b0;
        dir_load = 1'b0;
        checkOutput("wr_done", bst_done, 1);
        checkOutput("wr_ready_cycles", readyCycles, nwords + stalls);
        tick();
        checkOutput("wr_done_clear", bst_done, 0);
        checkOutput("wr_idle", bst_busy, 0);
    endtask

    task automatic doReadBurst(input logic [5:0] base, input int nwords);
        bst_start = 1'b1;
        bst_write = 1'b0;
        bst_base  = base;
        bst_len   = 6'(nwords - 1);
        tick();
        bst_start = 1'b0;
        dir_load  = 1'b0;
        checkOutput("rd_busy_start", bst_busy, 1);
        for (int k = 1; k <= nwords + 2; k++) begin
            tick();
            checkOutput("rd_valid", bst_dout_valid, 32'(k <= nwords));
            if (k <= nwords) checkOutput("rd_data", bst_dout, model[6'(int'(base) + k - 1)]);
            checkOutput("rd_done", bst_done, 32'(k == nwords + 1));
            checkOutput("rd_busy", bst_busy, 32'(k <= nwords + 1));
        end
    endtask

    initial begin
        dvecs[0] = '{1'b1, 6'b110011, 16'habcd, 16'habcd};
        dvecs[1] = '{1'b1, 6'd7,      16'h1234, 16'h1234};
        dvecs[2] = '{1'b0, 6'b110011, 16'hffff, 16'habcd};
        dvecs[3] = '{1'b0, 6'd7,      16'h0000, 16'h1234};
        dvecs[4] = '{1'b1, 6'd7,      16'h5a5a, 16'h5a5a};
        dvecs[5] = '{1'b0, 6'b110011, 16'h0000, 16'habcd};
        dvecs[6] = '{1'b0, 6'd7,      16'h0000, 16'h5a5a};

        #2 reset = 1'b1;
        #1;
        checkOutput("rst_ready", bst_din_ready, 0);
        checkOutput("rst_dout", bst_dout, 0);
        checkOutput("rst_valid", bst_dout_valid, 0);
        checkOutput("rst_busy", bst_busy, 0);
        checkOutput("rst_done", bst_done, 0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(dvecs[i]);

        // full-depth burst: every word written once, read back in order
        for (int i = 0; i < 64; i++) wdata[i] = 16'(i);
        doWriteBurst(6'd10, 64, -1, 1'b0, 1'b0);
        peek("full_base", 6'd10, 16'd0);
        peek("full_wrap", 6'd9, 16'd63);
        peek("full_mid", 6'd5, 16'd59);
        doReadBurst(6'd10, 64);

        // wrapping write with one stall and load masked while busy
        wdata[0] = 16'd1; wdata[1] = 16'd2; wdata[2] = 16'd3; wdata[3] = 16'd4;
        doWriteBurst(6'd62, 4, 2, 1'b0, 1'b1);
        peek("wrap_62", 6'd62, 16'd1);
        peek("wrap_63", 6'd63, 16'd2);
        peek("wrap_0", 6'd0, 16'd3);
        peek("wrap_1", 6'd1, 16'd4);
        peek("masked_load", 6'd5, 16'd59);
        doReadBurst(6'd62, 4);

        // same-edge direct write and burst start
        dir_load = 1'b1;
        dir_addr = 6'd5;
        dir_in   = 16'h1357;
        model[5] = 16'h1357;
        doReadBurst(6'd4, 3);
        peek("same_edge_load", 6'd5, 16'h1357);

        // reset two words into a six-word write
        bst_start = 1'b1; bst_write = 1'b1; bst_base = 6'd20; bst_len = 6'd5;
        tick();
        bst_start = 1'b0;
        bst_din_valid = 1'b1; bst_din = 16'haaa1;
        tick();
        bst_din = 16'haaa2;
        tick();
        model[20] = 16'haaa1;
        model[21] = 16'haaa2;
        bst_din = 16'haaa3;
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_busy", bst_busy, 0);
        checkOutput("mid_rst_ready", bst_din_ready, 0);
        checkOutput("mid_rst_done", bst_done, 0);
        checkOutput("mid_rst_dout", bst_dout, 0);
        checkOutput("mid_rst_valid", bst_dout_valid, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_rst_done", bst_done, 0);
            checkOutput("post_rst_busy", bst_busy, 0);
        end
        bst_din_valid = 1'b0;
        for (int a = 20; a < 26; a++) peek("mid_rst_mem", 6'(a), model[a]);

        // randomized traffic against the array model
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    dvec_t v;
                    v.load = 1'b1;
                    v.addr = 6'($urandom_range(0, 63));
                    v.din  = 16'($urandom);
                    v.exp  = v.din;
                    applyStimulus(v);
                end
                1: begin
                    logic [5:0] a;
                    a = 6'($urandom_range(0, 63));
                    peek("rand_peek", a, model[a]);
                end
                2: begin
                    int n;
                    n = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(1, 16);
                    for (int i = 0; i < n; i++) wdata[i] = 16'($urandom);
                    doWriteBurst(6'($urandom_range(0, 63)), n, -1, 1'b1, 1'b0);
                end
                default: begin
                    doReadBurst(6'($urandom_range(0, 63)), $urandom_range(1, 16));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
